fsqrt_issue: RTL

- Valid/ready control stage that sits directly upstream and downstream of the fixed-latency `fsqrt` core, whose ports are (clk, x, y).
- Accepts IEEE-754 single operands with a tag and drives the core input.
- Tracks in-flight operations alongside the core pipeline and substitutes special-case results (zero, inf, NaN, negative, denormal).
- Buffers results in an output FIFO so the free-running, unstallable core never loses data when the consumer back-pressures.

---
 rtl/fsqrt_issue.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fsqrt_issue.sv
// ---------------------------------------------------------------------------
// fsqrt_issue
//   Valid/ready wrapper around a free-running, fixed-latency single-precision
//   square-root core.  Operands go straight to the core; a shadow shift
//   register walks alongside the core pipeline carrying tag and special-case
//   information.  Results land in a small output FIFO.  A credit check stops
//   new operands while every FIFO slot is spoken for, so the core can never
//   overrun the FIFO.
//
// Parameters
//   LATENCY  core latency in clk edges from core_x to core_y (1..4)
//   TAG_W    width of the opaque tag
//   DEPTH    output FIFO entries (>= LATENCY+1)
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake
//   in_data, in_tag            IEEE-754 single operand and its tag
//   core_x / core_y            core input (combinational copy of in_data)
//                              and core output
//   out_valid/out_ready        result handshake
//   out_data, out_tag          result and its tag
//   out_invalid                IEEE invalid-operation flag of the result
// ---------------------------------------------------------------------------
module fsqrt_issue #(
   parameter int LATENCY = 2,
   parameter int TAG_W   = 4,
   parameter int DEPTH   = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      core_x,
   input  logic [31:0]      core_y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_invalid
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(LATENCY + 1);
   localparam int SW = $clog2(DEPTH + LATENCY + 1);
   localparam int EW = 32 + TAG_W + 1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic             special;
      logic [31:0]      sval;
      logic             invalid;
   } trk_t;

   // Returns {special, invalid, substituted result} for an operand.
   function automatic logic [33:0] classify(input logic [31:0] d);
      logic [33:0] r;
      r = {1'b0, 1'b0, 32'h0000_0000};
      if (d[30:23] == 8'h00) begin
         // zero and denormal both collapse to a signed zero
         r = {1'b1, 1'b0, d[31], 31'h0000_0000};
      end else if ((d[30:23] == 8'hFF) && (d[22:0] != 23'h00_0000)) begin
         r = {1'b1, 1'b0, 32'h7FC0_0000};
      end else if ((d[30:23] == 8'hFF) && !d[31]) begin
         r = {1'b1, 1'b0, 32'h7F80_0000};
      end else if (d[31]) begin
         // negative normal or -inf: domain error
         r = {1'b1, 1'b1, 32'h7FC0_0000};
      end else begin
         r = {1'b0, 1'b0, 32'h0000_0000};
      end
      return r;
   endfunction

   // Circular pointer increment; DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PW'(1);
      end
      return r;
   endfunction

   trk_t             r_trk [LATENCY];
   logic [EW-1:0]    r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_count;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [31:0]      r_out_data;
   logic [TAG_W-1:0] r_out_tag;
   logic             r_out_invalid;

   logic             w_accept;
   logic [33:0]      w_cls;
   logic             w_push;
   logic             w_pop;
   logic [EW-1:0]    w_push_entry;
   logic [PW-1:0]    w_rd_nxt;
   logic [PW-1:0]    w_wr_nxt;
   logic [CW-1:0]    w_count_nxt;
   logic [IW-1:0]    w_inflight_nxt;
   logic             w_credit_nxt;
   logic [EW-1:0]    w_head_nxt;

   assign w_accept  = in_valid & r_in_ready;
   assign core_x    = in_data;
   assign w_cls     = classify(in_data);
   assign w_push    = r_trk[LATENCY-1].valid;
   assign w_pop     = r_out_valid & out_ready;

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_data    = r_out_data;
   assign out_tag     = r_out_tag;
   assign out_invalid = r_out_invalid;

   // Entry leaving the tracking register: substituted value or core result.
   always_comb begin
      w_push_entry = '0;
      if (r_trk[LATENCY-1].special) begin
         w_push_entry = {r_trk[LATENCY-1].sval, r_trk[LATENCY-1].tag, r_trk[LATENCY-1].invalid};
      end else begin
         w_push_entry = {core_y, r_trk[LATENCY-1].tag, r_trk[LATENCY-1].invalid};
      end
   end

   // Next FIFO pointers and occupancy (pop happens before push).
   always_comb begin
      w_rd_nxt    = r_rd;
      w_wr_nxt    = r_wr;
      w_count_nxt = r_count;
      if (w_pop) begin
         w_rd_nxt = ptr_inc(r_rd);
      end else begin
         w_rd_nxt = r_rd;
      end
      if (w_push) begin
         w_wr_nxt = ptr_inc(r_wr);
      end else begin
         w_wr_nxt = r_wr;
      end
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Credit for the next cycle: operations still in the shadow register
   // after this edge plus FIFO occupancy after this edge.
   always_comb begin
      w_inflight_nxt = IW'(w_accept);
      for (int i = 0; i < LATENCY - 1; i++) begin
         w_inflight_nxt = w_inflight_nxt + IW'(r_trk[i].valid);
      end
      w_credit_nxt = (SW'(w_inflight_nxt) + SW'(w_count_nxt)) < SW'(DEPTH);
   end

   // Head entry after this edge; a push into an empty FIFO bypasses memory.
   always_comb begin
      w_head_nxt = '0;
      if (w_push && (r_wr == w_rd_nxt)) begin
         w_head_nxt = w_push_entry;
      end else begin
         w_head_nxt = r_mem[w_rd_nxt];
      end
   end

   // Shadow of the core pipeline; stage 0 loads every cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < LATENCY; i++) begin
            r_trk[i] <= '0;
         end
      end else begin
         r_trk[0] <= {w_accept, in_tag, w_cls[33], w_cls[31:0], w_cls[32]};
         for (int i = 1; i < LATENCY; i++) begin
            r_trk[i] <= r_trk[i-1];
         end
      end
   end

   // FIFO storage.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr] <= w_push_entry;
      end
   end

   // FIFO pointers, occupancy and input credit.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr       <= '0;
         r_rd       <= '0;
         r_count    <= '0;
         r_in_ready <= 1'b0;
      end else begin
         r_wr       <= w_wr_nxt;
         r_rd       <= w_rd_nxt;
         r_count    <= w_count_nxt;
         r_in_ready <= w_credit_nxt;
      end
   end

   // Registered copy of the FIFO head; zeroed while the FIFO is empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_out_valid   <= 1'b0;
         r_out_data    <= 32'h0000_0000;
         r_out_tag     <= '0;
         r_out_invalid <= 1'b0;
      end else if (w_count_nxt != CW'(0)) begin
         r_out_valid   <= 1'b1;
         r_out_data    <= w_head_nxt[EW-1 -: 32];
         r_out_tag     <= w_head_nxt[TAG_W:1];
         r_out_invalid <= w_head_nxt[0];
      end else begin
         r_out_valid   <= 1'b0;
         r_out_data    <= 32'h0000_0000;
         r_out_tag     <= '0;
         r_out_invalid <= 1'b0;
      end
   end

   fsqrt_issue_chk #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_chk (
      .clk   (clk),
      .rstn  (rstn),
      .push  (w_push),
      .pop   (w_pop),
      .count (r_count)
   );

endmodule

// ---------------------------------------------------------------------------
// fsqrt_issue_chk
//   Simulation-only checks on the output FIFO of fsqrt_issue.
//   Ports: clk, rstn, push, pop, count (current FIFO occupancy).
// ---------------------------------------------------------------------------
module fsqrt_issue_chk #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          rstn,
   input logic          push,
   input logic          pop,
   input logic [CW-1:0] count
);

   // The credit check must make a push into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
      !(push && !pop && (count == CW'(DEPTH))));

   a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(pop && (count == CW'(0))));

endmodule
